// File: rtl/async_lock_requester.sv
// async_lock_requester: synchronous client of one asynchronous arbiter-tree leaf.
// Turns acquire/release pulses into a four-phase req/ack handshake, synchronises
// the returned ack, reports ownership and records how long the last grant took.
module async_lock_requester #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             acquire_i,
  input  logic             release_i,
  output logic             req_o,
  input  logic             ack_i,
  output logic             granted_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] wait_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANTED = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_q, req_d;
  logic                   granted_q, granted_d;
  logic                   pend_q, pend_d;
  logic                   abort_q, abort_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   ack_s;
  logic                   acq_only;
  logic                   rel_only;
  logic                   both_pulses;

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Shift ack_i through the synchroniser; stage 0 is the only one touching the async input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_i};
  end

  // Next-state, handshake bookkeeping and misuse detection.
  always_comb begin
    acq_only    = acquire_i & ~release_i;
    rel_only    = release_i & ~acquire_i;
    both_pulses = acquire_i & release_i;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    state_d    = state_q;
    pend_d     = pend_q;
    abort_d    = abort_q;
    err_d      = err_q | both_pulses;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rel_only) err_d = 1'b1;
        if (ack_s) begin
          // Ack without a request: park in RELEASE until the tree drops it.
          state_d = ST_RELEASE;
          err_d   = 1'b1;
          if (acq_only) pend_d = 1'b1;
        end else if (acq_only) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (acq_only) err_d = 1'b1;
        if (rel_only) abort_d = 1'b1;
        // req stays up until ack arrives, even when aborted, to keep the handshake legal.
        if (ack_s) begin
          abort_d = 1'b0;
          if (abort_q | rel_only) begin
            state_d = ST_RELEASE;
          end else begin
            state_d    = ST_GRANTED;
            wait_cnt_d = cnt_inc;
          end
        end
      end
      ST_GRANTED: begin
        if (acq_only) err_d = 1'b1;
        if (rel_only) state_d = ST_RELEASE;
      end
      default: begin // ST_RELEASE
        if (rel_only) err_d = 1'b1;
        if (acq_only) begin
          if (pend_q) err_d = 1'b1;
          pend_d = 1'b1;
        end
        if (!ack_s) begin
          // A queued acquire goes straight back to REQ without an IDLE cycle.
          if (pend_q | acq_only) begin
            state_d = ST_REQ;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    req_d     = (state_d == ST_REQ) || (state_d == ST_GRANTED);
    granted_d = (state_d == ST_GRANTED);
  end

  // State and output registers; synchroniser resets high so a real ack low is awaited.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RELEASE;
      sync_q     <= {SYNC_STAGES{1'b1}};
      req_q      <= 1'b0;
      granted_q  <= 1'b0;
      pend_q     <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      req_q      <= req_d;
      granted_q  <= granted_d;
      pend_q     <= pend_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign req_o      = req_q;
  assign granted_o  = granted_q;
  assign busy_o     = (state_q == ST_REQ) | (state_q == ST_RELEASE) | pend_q;
  assign wait_cnt_o = wait_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_async_lock_requester.sv
// Directed bench for async_lock_requester: one default instance (CNT_W=16) and one
// narrow-counter instance (CNT_W=4) for the saturation case.
module tb_async_lock_requester;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        acquire_i, release_i, ack_i;
  logic        req_o, granted_o, busy_o, err_o;
  logic [15:0] wait_cnt_o;

  logic        rst_b_n;
  logic        acq_b, rel_b, ack_b;
  logic        req_b, granted_b, busy_b, err_b;
  logic [3:0]  wait_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  async_lock_requester #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .acquire_i  (acquire_i),
    .release_i  (release_i),
    .req_o      (req_o),
    .ack_i      (ack_i),
    .granted_o  (granted_o),
    .busy_o     (busy_o),
    .wait_cnt_o (wait_cnt_o),
    .err_o      (err_o)
  );

  async_lock_requester #(.SYNC_STAGES(2), .CNT_W(4)) dut_b (
    .clk        (clk),
    .reset_n    (rst_b_n),
    .acquire_i  (acq_b),
    .release_i  (rel_b),
    .req_o      (req_b),
    .ack_i      (ack_b),
    .granted_o  (granted_b),
    .busy_o     (busy_b),
    .wait_cnt_o (wait_cnt_b),
    .err_o      (err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_acq();
    acquire_i = 1'b1;
    tick();
    acquire_i = 1'b0;
  endtask

  task automatic pulse_rel();
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
  endtask

  // Reset instance A with ack low and let it settle into IDLE.
  task automatic reset_a();
    ack_i   = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ticks(3);
  endtask

  initial begin
    reset_n = 1'b0; acquire_i = 1'b0; release_i = 1'b0; ack_i = 1'b0;
    rst_b_n = 1'b0; acq_b = 1'b0; rel_b = 1'b0; ack_b = 1'b0;
    ticks(2);

    // 1: reset values, then busy for SYNC_STAGES+1 samples before IDLE
    check("rst_req", req_o, 0);
    check("rst_granted", granted_o, 0);
    check("rst_busy", busy_o, 1);
    check("rst_wait", wait_cnt_o, 0);
    check("rst_err", err_o, 0);
    reset_n = 1'b1;
    rst_b_n = 1'b1;
    check("settle_busy0", busy_o, 1);
    tick();
    check("settle_busy1", busy_o, 1);
    tick();
    check("settle_busy2", busy_o, 1);
    tick();
    check("idle_busy", busy_o, 0);
    check("idle_req", req_o, 0);

    // 2: acquire, grant after ack passes the synchroniser, wait_cnt = 5
    pulse_acq();                       // cycle 11: REQ
    check("acq_req", req_o, 1);
    check("acq_busy", busy_o, 1);
    ticks(2);                          // cycle 13
    ack_i = 1'b1;
    ticks(2);                          // cycle 15: ack_s high
    check("pregrant", granted_o, 0);
    tick();                            // cycle 16
    check("grant", granted_o, 1);
    check("grant_wait", wait_cnt_o, 5);
    check("grant_busy", busy_o, 0);
    ticks(4);                          // cycle 20
    pulse_rel();                       // cycle 21
    check("rel_req", req_o, 0);
    check("rel_granted", granted_o, 0);
    check("rel_busy", busy_o, 1);
    ack_i = 1'b0;
    ticks(2);
    check("rel_wait_busy", busy_o, 1);
    tick();
    check("rel_idle_busy", busy_o, 0);
    check("t2_err", err_o, 0);

    // 3: acquire queued in RELEASE while ack still high
    pulse_acq();
    ack_i = 1'b1;
    ticks(3);
    check("t3_grant", granted_o, 1);
    pulse_rel();
    check("t3_rel_req", req_o, 0);
    pulse_acq();
    check("pend_busy", busy_o, 1);
    check("pend_req", req_o, 0);
    check("pend_err", err_o, 0);
    ack_i = 1'b0;
    ticks(2);                          // ack_s now low
    check("pend_req_hold", req_o, 0);
    tick();
    check("pend_rereq", req_o, 1);
    check("pend_rereq_busy", busy_o, 1);
    ack_i = 1'b1;
    ticks(3);
    check("t3_regrant", granted_o, 1);
    check("t3_wait", wait_cnt_o, 3);
    pulse_rel();
    ack_i = 1'b0;
    ticks(3);
    check("t3_idle", busy_o, 0);

    // 4: abort in REQ holds req until ack, never grants
    pulse_acq();
    pulse_rel();
    check("abort_req_held", req_o, 1);
    ticks(3);
    check("abort_req_held2", req_o, 1);
    ack_i = 1'b1;
    ticks(2);                          // ack_s high
    check("abort_req_at_ack", req_o, 1);
    check("abort_no_grant", granted_o, 0);
    tick();
    check("abort_req_drop", req_o, 0);
    check("abort_no_grant2", granted_o, 0);
    check("abort_wait", wait_cnt_o, 3);
    check("abort_err", err_o, 0);
    ack_i = 1'b0;
    ticks(3);
    check("abort_idle", busy_o, 0);

    // 5a: acquire while GRANTED
    pulse_acq();
    ack_i = 1'b1;
    ticks(3);
    check("m_a_grant", granted_o, 1);
    pulse_acq();
    check("m_acq_granted_err", err_o, 1);
    check("m_acq_granted_keep", granted_o, 1);
    reset_a();
    check("m_reset_err", err_o, 0);
    check("m_reset_busy", busy_o, 0);

    // 5b: release while IDLE
    pulse_rel();
    check("m_rel_idle_err", err_o, 1);
    check("m_rel_idle_busy", busy_o, 0);

    // 5c: simultaneous pulses
    reset_a();
    acquire_i = 1'b1; release_i = 1'b1;
    tick();
    acquire_i = 1'b0; release_i = 1'b0;
    check("m_both_err", err_o, 1);
    check("m_both_req", req_o, 0);

    // 5d: ack high while IDLE
    reset_a();
    ack_i = 1'b1;
    ticks(2);
    check("m_ack_pre_err", err_o, 0);
    tick();
    check("m_ack_err", err_o, 1);
    check("m_ack_busy", busy_o, 1);
    reset_a();

    // 6a: CNT_W=4 counter saturates
    acq_b = 1'b1;
    tick();
    acq_b = 1'b0;
    check("b_req", req_b, 1);
    ticks(40);
    ack_b = 1'b1;
    ticks(3);
    check("b_grant", granted_b, 1);
    check("b_wait_sat", wait_cnt_b, 15);
    check("b_err", err_b, 0);

    // 6b: reset in GRANTED drops req immediately; no request until ack low
    pulse_acq();
    ack_i = 1'b1;
    ticks(3);
    check("r_grant", granted_o, 1);
    reset_n = 1'b0;
    #1;
    check("r_req_async", req_o, 0);
    check("r_granted_async", granted_o, 0);
    #1;
    reset_n = 1'b1;
    tick();
    pulse_acq();
    ticks(4);
    check("r_hold_req", req_o, 0);
    check("r_hold_busy", busy_o, 1);
    ack_i = 1'b0;
    ticks(2);
    check("r_hold_req2", req_o, 0);
    tick();
    check("r_rereq", req_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
